cycle_controller: RTL and testbench

CYCLE_CONTROLLER -- requirements
Module: cycle_controller

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cycle_controller_if.sv | 32 +++
 rtl/sat_counter.sv | 23 ++
 rtl/cycle_controller.sv | 136 +++++++++++++
 tb/tb_cycle_controller.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU cycle sequencer.
// Holds the controller state enum and the default stall watchdog limit.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC1,
      S_EXEC2,
      S_HALTED,
      S_FAULT
   } state_t;

   localparam int STALL_LIMIT_DEFAULT = 1023;

   // Counter width able to hold limit+1 without wrapping.
   function automatic int cnt_width(input int limit);
      return $clog2(limit + 2);
   endfunction

endpackage

// File: rtl/cycle_controller_if.sv
// cycle_controller_if: decode/bus inputs and sequencer outputs.
// master is the controller side, slave is the surrounding CPU/bus.
interface cycle_controller_if;

   logic        waitrequest;
   logic        halt;
   logic        mem_read_req;
   logic        mem_write_req;
   logic        needs_exec2;
   logic        fetch;
   logic        exec1;
   logic        exec2;
   logic        mem_read;
   logic        mem_write;
   logic        active;
   logic        fault;
   logic [31:0] instr_count;
   logic [15:0] stall_count;

   modport master (
      input  waitrequest, halt, mem_read_req, mem_write_req, needs_exec2,
      output fetch, exec1, exec2, mem_read, mem_write, active, fault,
      output instr_count, stall_count
   );

   modport slave (
      output waitrequest, halt, mem_read_req, mem_write_req, needs_exec2,
      input  fetch, exec1, exec2, mem_read, mem_write, active, fault,
      input  instr_count, stall_count
   );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with sync clear.
// Shared by the total-stall and consecutive-stall counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && count != '1) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cycle_controller.sv
// cycle_controller: FETCH/EXEC1/EXEC2 sequencer with stall accounting
// and a consecutive-stall watchdog that parks the CPU in FAULT.
module cycle_controller
   import cpu_pkg::*;
#(
   parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
   input logic                clk,
   input logic                reset,
   cycle_controller_if.master bus
);

   localparam int CW = cnt_width(STALL_LIMIT);

   state_t          state;
   state_t          state_nx;
   logic            stall;
   logic            access;
   logic            retire;
   logic            over;
   logic            f_s;
   logic            e1_s;
   logic            e2_s;
   logic            rd_s;
   logic            wr_s;
   logic            act_s;
   logic            flt_s;
   logic [CW-1:0]   consec;
   logic [31:0]     instr_q;
   logic [15:0]     stall_q;

   assign access = bus.mem_write_req | bus.mem_read_req;
   assign over   = (consec == CW'(STALL_LIMIT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      f_s      = 1'b0;
      e1_s     = 1'b0;
      e2_s     = 1'b0;
      rd_s     = 1'b0;
      wr_s     = 1'b0;
      act_s    = 1'b0;
      flt_s    = 1'b0;
      unique case (state)
         S_FETCH: begin
            act_s = 1'b1;
            if (bus.halt) begin
               state_nx = S_HALTED;
            end else begin
               rd_s = 1'b1;
               if (bus.waitrequest) begin
                  stall = 1'b1;
               end else begin
                  f_s      = 1'b1;
                  state_nx = S_EXEC1;
               end
            end
         end
         S_EXEC1: begin
            act_s = 1'b1;
            wr_s  = bus.mem_write_req;
            rd_s  = bus.mem_read_req & ~bus.mem_write_req;
            if (access && bus.waitrequest) begin
               stall = 1'b1;
            end else begin
               e1_s     = 1'b1;
               state_nx = bus.needs_exec2 ? S_EXEC2 : S_FETCH;
            end
         end
         S_EXEC2: begin
            act_s    = 1'b1;
            e2_s     = 1'b1;
            state_nx = S_FETCH;
         end
         S_HALTED: begin
         end
         S_FAULT: begin
            flt_s = 1'b1;
         end
         default: begin
            state_nx = S_FAULT;
         end
      endcase
      // A stall that would push the run past the limit trips the watchdog.
      if (stall && over) begin
         state_nx = S_FAULT;
      end
   end

   assign retire = (e1_s & ~bus.needs_exec2) | e2_s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q <= '0;
      end else if (retire) begin
         instr_q <= instr_q + 32'd1;
      end
   end

   sat_counter #(.W(16)) u_stall_total (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (stall),
      .count (stall_q)
   );

   sat_counter #(.W(CW)) u_stall_run (
      .clk   (clk),
      .reset (reset),
      .clr   (~stall),
      .inc   (stall),
      .count (consec)
   );

   // Reset gates the strobes so they drop without waiting for a clock.
   assign bus.fetch       = f_s & reset;
   assign bus.exec1       = e1_s & reset;
   assign bus.exec2       = e2_s & reset;
   assign bus.mem_read    = rd_s & reset;
   assign bus.mem_write   = wr_s & reset;
   assign bus.active      = act_s & reset;
   assign bus.fault       = flt_s & reset;
   assign bus.instr_count = instr_q;
   assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_cycle_controller.sv
// tb_cycle_controller: two controllers (default limit and limit 3) run the
// same stimulus; a queue-based scoreboard checks them against a model.
module tb_cycle_controller;

   typedef struct packed {
      logic        f;
      logic        e1;
      logic        e2;
      logic        rd;
      logic        wr;
      logic        act;
      logic        flt;
      logic [31:0] ic;
      logic [15:0] sc;
   } exp_t;

   typedef struct {
      int          phase;
      bit          halted;
      bit          faulted;
      int          run;
      logic [31:0] ic;
      int          sc;
      int          limit;
   } mdl_t;

   logic clk;
   logic rst_b;
   logic wreq;
   logic hlt;
   logic rrq;
   logic wrq;
   logic ne2;

   int   n_cmp;
   int   n_bad;
   exp_t q0[$];
   exp_t q1[$];
   mdl_t m[2];

   cycle_controller_if ifa ();
   cycle_controller_if ifb ();

   assign ifa.waitrequest   = wreq;
   assign ifa.halt          = hlt;
   assign ifa.mem_read_req  = rrq;
   assign ifa.mem_write_req = wrq;
   assign ifa.needs_exec2   = ne2;
   assign ifb.waitrequest   = wreq;
   assign ifb.halt          = hlt;
   assign ifb.mem_read_req  = rrq;
   assign ifb.mem_write_req = wrq;
   assign ifb.needs_exec2   = ne2;

   cycle_controller dut_a (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ifa)
   );

   cycle_controller #(.STALL_LIMIT(3)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: one instruction walks fetch -> exec1 -> (exec2) by phase.
   function automatic exp_t step(input int k);
      exp_t e;
      bit   st;
      e  = '0;
      st = 1'b0;
      if (!rst_b) begin
         m[k].phase   = 0;
         m[k].halted  = 1'b0;
         m[k].faulted = 1'b0;
         m[k].run     = 0;
         m[k].ic      = '0;
         m[k].sc      = 0;
         return e;
      end
      e.ic  = m[k].ic;
      e.sc  = 16'(m[k].sc);
      e.flt = m[k].faulted;
      if (m[k].halted || m[k].faulted) return e;
      e.act = 1'b1;
      if (m[k].phase == 0 && hlt) begin
         m[k].halted = 1'b1;
         return e;
      end
      if (m[k].phase == 0) begin
         e.rd = 1'b1;
         st   = wreq;
      end
      if (m[k].phase == 1) begin
         e.wr = wrq;
         e.rd = rrq & ~wrq;
         st   = wreq & (rrq | wrq);
      end
      if (st) begin
         if (m[k].sc < 65535) m[k].sc = m[k].sc + 1;
         m[k].run = m[k].run + 1;
         if (m[k].run > m[k].limit) m[k].faulted = 1'b1;
         return e;
      end
      m[k].run = 0;
      case (m[k].phase)
         0: begin
            e.f        = 1'b1;
            m[k].phase = 1;
         end
         1: begin
            e.e1 = 1'b1;
            if (ne2) begin
               m[k].phase = 2;
            end else begin
               m[k].phase = 0;
               m[k].ic    = m[k].ic + 32'd1;
            end
         end
         default: begin
            e.e2       = 1'b1;
            m[k].phase = 0;
            m[k].ic    = m[k].ic + 32'd1;
         end
      endcase
      return e;
   endfunction

   task automatic drive(input logic rs, input logic w, input logic h,
                        input logic rr, input logic wr, input logic n);
      @(negedge clk);
      #1;
      rst_b = rs;
      wreq  = w;
      hlt   = h;
      rrq   = rr;
      wrq   = wr;
      ne2   = n;
      q0.push_back(step(0));
      q1.push_back(step(1));
   endtask

   task automatic rst_cycles();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input exp_t a, input exp_t e);
      n_cmp++;
      if ({a.f, a.e1, a.e2, a.rd, a.wr, a.act, a.flt} !==
          {e.f, e.e1, e.e2, e.rd, e.wr, e.act, e.flt}) begin
         n_bad++;
         $display("FAIL %s strobes t=%0t got f/e1/e2/rd/wr/act/flt=%b want %b",
                  nm, $time, {a.f, a.e1, a.e2, a.rd, a.wr, a.act, a.flt},
                  {e.f, e.e1, e.e2, e.rd, e.wr, e.act, e.flt});
      end
      n_cmp++;
      if (a.ic !== e.ic) begin
         n_bad++;
         $display("FAIL %s instr_count t=%0t got %0d want %0d",
                  nm, $time, a.ic, e.ic);
      end
      n_cmp++;
      if (a.sc !== e.sc) begin
         n_bad++;
         $display("FAIL %s stall_count t=%0t got %0d want %0d",
                  nm, $time, a.sc, e.sc);
      end
   endtask

   initial begin
      exp_t a;
      forever begin
         @(negedge clk);
         #3;
         if (q0.size() > 0) begin
            a = {ifa.fetch, ifa.exec1, ifa.exec2, ifa.mem_read, ifa.mem_write,
                 ifa.active, ifa.fault, ifa.instr_count, ifa.stall_count};
            chk("lim1023", a, q0.pop_front());
         end
         if (q1.size() > 0) begin
            a = {ifb.fetch, ifb.exec1, ifb.exec2, ifb.mem_read, ifb.mem_write,
                 ifb.active, ifb.fault, ifb.instr_count, ifb.stall_count};
            chk("lim3", a, q1.pop_front());
         end
      end
   end

   initial begin
      int p;
      n_cmp      = 0;
      n_bad      = 0;
      rst_b      = 1'b0;
      wreq       = 1'b0;
      hlt        = 1'b0;
      rrq        = 1'b0;
      wrq        = 1'b0;
      ne2        = 1'b0;
      m[0].limit = 1023;
      m[1].limit = 3;

      // three plain instructions
      rst_cycles();
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // four fetch stalls, then the fetch commits
      rst_cycles();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // load with two exec1 stalls and an exec2 writeback
      rst_cycles();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // write wins over read; no-access exec1 ignores waitrequest
      rst_cycles();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // halt beats waitrequest
      rst_cycles();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // long stall: watchdog trips only on the limit-3 controller
      rst_cycles();
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

      // reset dropped in the middle of an exec1 stall
      rst_cycles();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int b = 0; b < 24; b++) begin
         p = (b % 3 == 0) ? 10 : ((b % 3 == 1) ? 35 : 75);
         rst_cycles();
         for (int i = 0; i < 150; i++) begin
            drive(1'b1, 1'($urandom_range(99) < p),
                  1'($urandom_range(299) == 0), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
         end
      end

      @(negedge clk);
      #5;
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain left %0d/%0d want 0/0", q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
